// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out shift engine.
//
// Accepts an N-bit word over a din_valid/din_ready handshake and emits it one bit per accepted
// serial beat on sout/sout_valid/sout_ready, with sout_last marking the final bit of each word.
// The final beat of a word and the load of the next word can share an edge, so back-to-back
// words stream with no idle cycle.
//
// Build option: define PISO_LSB_FIRST_EN to emit LSB first (shift right). Left undefined, the
// word goes out MSB first (shift left). Handshake, latency and sout_last timing are the same in
// both builds.

module piso_serializer #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         sout,
    output logic         sout_valid,
    input  logic         sout_ready,
    output logic         sout_last,
    output logic         busy
);

    // Counter holds the number of beats still to go after the current one.
    localparam int unsigned    CntW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(N - 1);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [N-1:0]    r_shift;
    logic [N-1:0]    w_shift_d;
    logic [N-1:0]    w_shift_adv;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;
    logic            w_load;
    logic            w_beat;
    logic            w_cnt_zero;

`ifdef PISO_LSB_FIRST_EN
    // LSB first: the output end is bit 0, so the register moves right.
    assign w_shift_adv = {1'b0, r_shift[N-1:1]};
    assign sout        = r_shift[0];
`else
    // MSB first: the output end is bit N-1, so the register moves left.
    assign w_shift_adv = {r_shift[N-2:0], 1'b0};
    assign sout        = r_shift[N-1];
`endif

    // Handshake decode. din_ready opens on the final beat so the next word loads on that edge.
    always_comb begin
        sout_valid = (r_state == StShift);
        busy       = sout_valid;
        w_cnt_zero = (r_cnt == '0);
        sout_last  = sout_valid & w_cnt_zero;
        din_ready  = (r_state == StIdle) | (sout_last & sout_ready);
        w_load     = din_valid & din_ready;
        w_beat     = sout_valid & sout_ready;
    end

    // Next-state logic: a load always wins, since it can only coincide with the final beat.
    always_comb begin
        w_state_d = r_state;
        w_shift_d = r_shift;
        w_cnt_d   = r_cnt;
        if (w_load) begin
            w_state_d = StShift;
            w_shift_d = din;
            w_cnt_d   = CntMax;
        end else if (w_beat) begin
            if (w_cnt_zero) begin
                // Register is left unshifted so sout keeps showing the last bit while idle.
                w_state_d = StIdle;
            end else begin
                w_shift_d = w_shift_adv;
                w_cnt_d   = r_cnt - CntW'(1);
            end
        end
    end

    // State register with synchronous reset taking priority over load and beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_shift <= w_shift_d;
            r_cnt   <= w_cnt_d;
        end
    end

endmodule
